// File: rtl/instr_issue.sv
// instr_issue: instruction FIFO, IR decode and start/waiting issue handshake with the controller
module instr_issue #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [15:0]              in_instr,
  output logic                     in_ready,
  input  logic                     waiting,
  input  logic [1:0]               reg_sel,
  output logic                     start,
  output logic [2:0]               opcode,
  output logic [1:0]               ALU_op,
  output logic [1:0]               shift_op,
  output logic [2:0]               reg_addr,
  output logic [15:0]              sximm8,
  output logic [15:0]              sximm5,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic [CNT_W-1:0]         retired_cnt,
  output logic [CNT_W-1:0]         illegal_cnt
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, ISSUE, CHECK, EXEC} state_t;
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0] ir;
  logic push, pop, retire, refuse;
  assign in_ready = fifo_count != (AW+1)'(DEPTH);
  assign push = in_valid && in_ready;
  assign pop = state == IDLE && fifo_count != '0 && waiting;
  assign retire = state == EXEC && waiting;
  assign refuse = state == CHECK && waiting;
  assign start = state == ISSUE;
  assign busy = state != IDLE;
  always_comb begin
    state_nx = state;
    state_nx = (state == IDLE) ? (pop ? ISSUE : IDLE) :
               (state == ISSUE) ? CHECK : (waiting ? IDLE : EXEC);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_nx;
  // Storage needs no reset: an empty count already makes stale entries unreachable.
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_instr;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      ir <= '0;
      retired_cnt <= '0;
      illegal_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        ir <= mem[rd_ptr];
      end
      fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
      if (retire && retired_cnt != '1) retired_cnt <= retired_cnt + 1'b1;
      if (refuse && illegal_cnt != '1) illegal_cnt <= illegal_cnt + 1'b1;
    end
  assign opcode = ir[15:13];
  assign ALU_op = ir[12:11];
  assign shift_op = ir[4:3];
  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};
  assign reg_addr = reg_sel == 2'b10 ? ir[10:8] :
                    reg_sel == 2'b01 ? ir[7:5] :
                    reg_sel == 2'b00 ? ir[2:0] : 3'b000;
endmodule

// File: tb/tb_instr_issue.sv
// tb_instr_issue: scoreboard bench; stimulus queues expected decode per issue, monitor checks on each start pulse
module tb_instr_issue;
  logic clk = 0, rst = 1, in_valid = 0, hold = 0, ctrl_wait = 1;
  logic [15:0] in_instr = '0;
  logic [1:0] reg_sel = 2'b10;
  logic waiting, in_ready, start, busy;
  logic [2:0] opcode, reg_addr, fifo_count;
  logic [1:0] ALU_op, shift_op;
  logic [15:0] sximm8, sximm5;
  logic [7:0] retired_cnt, illegal_cnt;
  int checks = 0, failures = 0, n_start = 0, exec_len = 1;
  typedef struct packed {
    logic [2:0] op;
    logic [1:0] alu;
    logic [1:0] sh;
    logic [15:0] s8;
    logic [15:0] s5;
  } exp_t;
  exp_t sb[$];
  assign waiting = ctrl_wait && !hold;
  instr_issue #(.DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .waiting(waiting), .reg_sel(reg_sel), .start(start), .opcode(opcode), .ALU_op(ALU_op),
    .shift_op(shift_op), .reg_addr(reg_addr), .sximm8(sximm8), .sximm5(sximm5), .busy(busy),
    .fifo_count(fifo_count), .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // Monitor: every start pulse consumes one scoreboard entry.
  initial begin
    exp_t e, got;
    logic prev_start;
    prev_start = 0;
    forever begin
      @(negedge clk);
      if (!rst && start) begin
        n_start++;
        checks++;
        got = {opcode, ALU_op, shift_op, sximm8, sximm5};
        if (prev_start) begin
          failures++;
          $display("FAIL start_width: start high two cycles running");
        end else if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_start: got decode %0h with empty scoreboard", got);
        end else begin
          e = sb.pop_front();
          if (got !== e) begin
            failures++;
            $display("FAIL decode: got %0h expected %0h", got, e);
          end
        end
      end
      prev_start = start && !rst;
    end
  end
  // Controller model: accepts everything except opcode 011, busy for exec_len EXEC cycles.
  initial forever begin
    @(negedge clk);
    if (!rst && start && opcode != 3'b011) begin
      ctrl_wait = 0;
      repeat (exec_len + 1) @(negedge clk);
      ctrl_wait = 1;
    end
  end
  task automatic push(input logic [15:0] ins, input bit acc, input exp_t e);
    chk("in_ready", in_ready, acc);
    in_valid = 1;
    in_instr = ins;
    if (acc) sb.push_back(e);
    @(negedge clk);
    in_valid = 0;
  endtask
  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((busy || fifo_count != 0 || !ctrl_wait) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < budget, 1);
  endtask
  initial begin
    int s, w;
    repeat (2) @(negedge clk);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_start_busy", {start, busy}, 0);
    chk("rst_counters", {retired_cnt, illegal_cnt}, 0);
    chk("rst_decode", {opcode, ALU_op, shift_op, reg_addr, sximm8}, 0);
    chk("rst_sximm5", sximm5, 0);
    rst = 0;
    @(negedge clk);
    push(16'hD007, 1, {3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007});
    wait_idle(50);
    chk("mov_retired", retired_cnt, 1);
    chk("mov_busy", busy, 0);
    chk("mov_reg_addr", reg_addr, 0);
    push(16'hA140, 1, {3'b101, 2'b00, 2'b00, 16'h0040, 16'h0000});
    wait_idle(50);
    chk("add_retired", retired_cnt, 2);
    reg_sel = 2'b10; #1 chk("rn", reg_addr, 1);
    reg_sel = 2'b01; #1 chk("rd", reg_addr, 2);
    reg_sel = 2'b00; #1 chk("rm", reg_addr, 0);
    reg_sel = 2'b11; #1 chk("sel11", reg_addr, 0);
    reg_sel = 2'b10;
    @(negedge clk);
    push(16'h6000, 1, {3'b011, 2'b00, 2'b00, 16'h0000, 16'h0000});
    push(16'hD0FF, 1, {3'b110, 2'b10, 2'b11, 16'hFFFF, 16'hFFFF});
    wait_idle(50);
    chk("illegal_cnt", illegal_cnt, 1);
    chk("illegal_retired", retired_cnt, 3);
    hold = 1;
    push(16'hD001, 1, {3'b110, 2'b10, 2'b00, 16'h0001, 16'h0001});
    push(16'hD002, 1, {3'b110, 2'b10, 2'b00, 16'h0002, 16'h0002});
    push(16'hD003, 1, {3'b110, 2'b10, 2'b00, 16'h0003, 16'h0003});
    push(16'hD004, 1, {3'b110, 2'b10, 2'b00, 16'h0004, 16'h0004});
    chk("full_count", fifo_count, 4);
    push(16'hD005, 0, {3'b110, 2'b10, 2'b00, 16'h0005, 16'h0005});
    chk("full_drop_count", fifo_count, 4);
    chk("full_busy", busy, 0);
    hold = 0;
    wait_idle(100);
    chk("full_retired", retired_cnt, 7);
    push(16'hA140, 1, {3'b101, 2'b00, 2'b00, 16'h0040, 16'h0000});
    push(16'hD007, 1, {3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007});
    wait_idle(50);
    chk("wrap_retired", retired_cnt, 9);
    exec_len = 20;
    push(16'hD001, 1, {3'b110, 2'b10, 2'b00, 16'h0001, 16'h0001});
    push(16'hD002, 1, {3'b110, 2'b10, 2'b00, 16'h0002, 16'h0002});
    push(16'hD003, 1, {3'b110, 2'b10, 2'b00, 16'h0003, 16'h0003});
    repeat (2) @(negedge clk);
    chk("exec_busy", busy, 1);
    chk("exec_count", fifo_count, 2);
    rst = 1;
    #1;
    chk("arst_count_ready", {fifo_count, in_ready}, 1);
    chk("arst_start_busy", {start, busy}, 0);
    chk("arst_counters", {retired_cnt, illegal_cnt}, 0);
    chk("arst_decode", {opcode, ALU_op, sximm8}, 0);
    sb.delete();
    @(negedge clk);
    rst = 0;
    s = n_start;
    repeat (30) @(negedge clk);
    chk("post_rst_no_start", n_start, s);
    chk("post_rst_count", fifo_count, 0);
    exec_len = 1;
    wait_idle(50);
    for (int i = 0; i < 260; i++) begin
      w = 0;
      while (!in_ready && w < 20) begin
        @(negedge clk);
        w++;
      end
      push(16'hD007, 1, {3'b110, 2'b10, 2'b00, 16'h0007, 16'h0007});
    end
    wait_idle(2000);
    chk("sat_retired", retired_cnt, 8'hFF);
    chk("sat_illegal", illegal_cnt, 0);
    chk("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/instr_issue.md
Name: instr_issue

Overview:
Instruction queue and decode stage that sits directly upstream of the datapath controller. It buffers 16-bit instructions in a small FIFO and loads the head entry into an instruction register. It decodes that register into the opcode, ALU_op, shift_op, register-number and immediate fields the controller and datapath consume. It then runs the start/waiting handshake with the controller, issuing one instruction at a time and counting retired and illegal instructions.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
CNT_W, 8, width of retired/illegal counters

Ports:
clk  input  1  clock, all state updates on posedge
rst  input  1  asynchronous active-high reset
in_valid  input  1  upstream instruction valid
in_instr  input  16  upstream instruction word
in_ready  output  1  FIFO can accept (= !full)
waiting  input  1  controller idle indication
reg_sel  input  2  controller register-field select
start  output  1  one-cycle issue pulse to controller
opcode  output  3  IR[15:13]
ALU_op  output  2  IR[12:11]
shift_op  output  2  IR[4:3]
reg_addr  output  3  register number selected by reg_sel
sximm8  output  16  IR[7:0] sign-extended
sximm5  output  16  IR[4:0] sign-extended
busy  output  1  state != IDLE
fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries
retired_cnt  output  CNT_W  instructions completed
illegal_cnt  output  CNT_W  instructions the controller refused

Behaviour:
- Reset (async, rst=1) forces:
  - FIFO empty: fifo_count=0, in_ready=1.
  - IR=16'h0000, state=IDLE, start=0, busy=0, both counters 0.
  - Decode outputs therefore all 0.
- FIFO:
  - Push when in_valid && in_ready. Pop only on the IDLE->ISSUE transition.
  - Pointers wrap modulo DEPTH.
  - When full, in_ready=0; a push attempted while full is ignored, even in a cycle where a pop also occurs.
  - Push and pop in the same cycle with 0<count<DEPTH: count unchanged.
  - Push into an empty FIFO is not visible to pop until the next cycle (no bypass).
- Decode: purely combinational from IR.
  - reg_addr = IR[10:8] (Rn) when reg_sel=2'b10, IR[7:5] (Rd) when 2'b01, IR[2:0] (Rm) when 2'b00.
  - reg_addr = 3'b000 when reg_sel=2'b11.
  - IR changes only on a pop, so decode outputs stay stable for the whole execution.
- FSM (registered state):
  - IDLE: if fifo_count>0 && waiting=1, load IR from the FIFO head, pop, go to ISSUE. Otherwise stay.
  - ISSUE: start=1 for exactly this cycle. Next state is CHECK.
  - CHECK: the controller has sampled start. If waiting=0, go to EXEC. If waiting=1, the controller refused the opcode/ALU_op pair: illegal_cnt += 1, go to IDLE.
  - EXEC: stay while waiting=0. When waiting=1, retired_cnt += 1, go to IDLE.
- Issue latency: with a non-empty FIFO and an idle controller, start is asserted 1 cycle after the pop decision. Back-to-back instructions issue at least 3 cycles plus execution length apart.
- start is 0 in every state except ISSUE.
- Counters saturate at 2^CNT_W-1; they do not wrap.
- Reset mid-operation (any state) immediately abandons the current instruction and clears FIFO contents; it is not counted in either counter.
- Pushes continue to be accepted during ISSUE/CHECK/EXEC.

Test Plan:
- Reset, then push 16'hD007 (MOV R0,#7) with waiting=1 -> in_ready=1; IR loads next cycle; start high exactly one cycle with opcode=3'b110, ALU_op=2'b10, sximm8=16'h0007; reg_addr=0 when reg_sel=2'b10. Model controller drops waiting for 1 cycle -> retired_cnt=1, busy=0.
- Push 16'hA140 (ADD R2,R1,R0), sweep reg_sel through 10/01/00 -> reg_addr=1/2/0, shift_op=2'b00. A 16'hD0FF push -> sximm8=16'hFFFF.
- Push 16'h6000 (illegal opcode) and hold waiting=1 throughout -> start pulses once; in CHECK illegal_cnt=1, retired_cnt unchanged, FSM returns to IDLE and issues the next queued instruction.
- Hold waiting=0 and push 5 instructions with DEPTH=4 -> in_ready=0 after the 4th; the 5th is dropped; fifo_count=4. Release waiting=1 -> four issues occur in push order, and the FIFO pointer wraps correctly on refill.
- Assert rst during EXEC with 2 entries queued -> all outputs return to reset values within the same cycle; no counter increment; start stays 0 after reset is released until a new push.
- Force 260 retirements -> retired_cnt holds at 8'hFF.
